// File: rtl/fifo_unpack_reader.sv
// fifo_unpack_reader: dequeues {b,a} packed elements and emits them as two items, a then b.
// Latency: first item is presented the cycle after the dequeue strobe; one element per two cycles sustained.
// Backpressure: dst_enq_rdy low freezes state and payload; no new dequeue until the held b item leaves.
module fifo_unpack_reader #(
    parameter int A_WIDTH = 6,
    parameter int B_WIDTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [A_WIDTH+B_WIDTH-1:0] src_first_dat,
    input  logic                       src_first_rdy,
    input  logic                       src_deq_rdy,
    output logic                       src_deq_ena,
    output logic                       dst_enq_ena,
    output logic [A_WIDTH:0]           dst_enq_dat,
    input  logic                       dst_enq_rdy,
    output logic [15:0]                count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEND_A = 2'd1;
    localparam logic [1:0] SEND_B = 2'd2;

    logic [1:0]                 r_state;
    logic [A_WIDTH+B_WIDTH-1:0] r_hold;
    logic [15:0]                r_count;

    logic                       w_deq_ena;
    logic                       w_enq_ena;
    logic                       w_xfer;
    logic [A_WIDTH-1:0]         w_b_ext;

    // Dequeue when the hold register is free now, or will be freed by this cycle's b transfer.
    always_comb begin
        w_deq_ena = ((r_state == IDLE) || ((r_state == SEND_B) && dst_enq_rdy))
                    && src_first_rdy && src_deq_rdy;
    end

    // Enqueue strobe depends on state only, never on downstream ready.
    always_comb begin
        w_enq_ena = (r_state == SEND_A) || (r_state == SEND_B);
        w_xfer    = w_enq_ena && dst_enq_rdy;
    end

    // Zero-extend field b to the payload width (works for B_WIDTH == A_WIDTH too).
    always_comb begin
        w_b_ext = '0;
        w_b_ext[B_WIDTH-1:0] = r_hold[A_WIDTH+B_WIDTH-1:A_WIDTH];
    end

    // Output payload: {last, data}; all zeros when nothing is held.
    always_comb begin
        dst_enq_dat = '0;
        case (r_state)
            SEND_A:  dst_enq_dat = {1'b0, r_hold[A_WIDTH-1:0]};
            SEND_B:  dst_enq_dat = {1'b1, w_b_ext};
            default: dst_enq_dat = '0;
        endcase
    end

    // State and hold register: capture on dequeue, advance only on an accepted transfer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_hold  <= '0;
        end else if (w_deq_ena) begin
            r_state <= SEND_A;
            r_hold  <= src_first_dat;
        end else begin
            case (r_state)
                IDLE:    r_state <= IDLE;
                SEND_A:  if (w_xfer) r_state <= SEND_B;
                SEND_B:  if (w_xfer) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Completed-element counter: bumps when the b item is accepted, wraps naturally at 16 bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (w_xfer && (r_state == SEND_B)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign src_deq_ena = w_deq_ena;
    assign dst_enq_ena = w_enq_ena;
    assign count       = r_count;

endmodule

// File: tb/tb_fifo_unpack_reader.sv
// Bench for fifo_unpack_reader: directed element sequences, expected items queued at issue time.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// A monitor process pops and compares every accepted downstream item.
module tb_fifo_unpack_reader;

    localparam int AW = 6;
    localparam int BW = 4;

    logic             clk;
    logic             rst;
    logic [AW+BW-1:0] src_first;
    logic             src_first_rdy;
    logic             src_deq_rdy;
    logic             src_deq_ena;
    logic             dst_enq_ena;
    logic [AW:0]      dst_enq_v;
    logic             dst_enq_rdy;
    logic [15:0]      count;

    int checks = 0;
    int errors = 0;
    logic [AW:0] exp_q[$];

    fifo_unpack_reader #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
        .CLK           (clk),
        .RST           (rst),
        .src_first_dat (src_first),
        .src_first_rdy (src_first_rdy),
        .src_deq_rdy   (src_deq_rdy),
        .src_deq_ena   (src_deq_ena),
        .dst_enq_ena   (dst_enq_ena),
        .dst_enq_dat   (dst_enq_v),
        .dst_enq_rdy   (dst_enq_rdy),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted item must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && dst_enq_ena && dst_enq_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL item_unexpected: got %0h expected none at %0t", dst_enq_v, $time);
            end else begin
                logic [AW:0] e;
                e = exp_q.pop_front();
                if (dst_enq_v !== e) begin
                    errors++;
                    $display("FAIL item: got %0h expected %0h at %0t", dst_enq_v, e, $time);
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        src_first     = '0;
        src_first_rdy = 1'b0;
        src_deq_rdy   = 1'b1;
        dst_enq_rdy   = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_enq_ena", dst_enq_ena, 0);
        chk("rst_v",       dst_enq_v,   0);
        chk("rst_count",   count,       0);
        chk("rst_deq_ena_idle", src_deq_ena, 0);
        src_first     = 10'h2A5;
        src_first_rdy = 1'b1;
        #1;
        chk("rst_deq_ena_follows", src_deq_ena, 1);
        tick();
        chk("rst_hold_idle", dst_enq_ena, 0);

        // Single element, dequeued on the first edge after release
        rst = 1'b0;
        exp_q.push_back(7'h25);
        exp_q.push_back(7'h4A);
        tick();
        src_first_rdy = 1'b0;
        chk("single_a_ena", dst_enq_ena, 1);
        chk("single_a_v",   dst_enq_v,   7'h25);
        tick();
        chk("single_b_v",   dst_enq_v,   7'h4A);
        tick();
        chk("single_count", count, 1);
        chk("single_idle",  dst_enq_ena, 0);

        // Back-to-back elements
        src_first     = 10'h3FF;
        src_first_rdy = 1'b1;
        exp_q.push_back(7'h3F);
        exp_q.push_back(7'h4F);
        exp_q.push_back(7'h00);
        exp_q.push_back(7'h40);
        tick();
        src_first = 10'h000;
        chk("b2b_deq_in_a", src_deq_ena, 0);
        chk("b2b_ena1", dst_enq_ena, 1);
        tick();
        chk("b2b_deq_in_b", src_deq_ena, 1);
        chk("b2b_ena2", dst_enq_ena, 1);
        tick();
        src_first_rdy = 1'b0;
        chk("b2b_ena3", dst_enq_ena, 1);
        chk("b2b_v3",   dst_enq_v, 7'h00);
        tick();
        chk("b2b_ena4", dst_enq_ena, 1);
        chk("b2b_last_no_deq", src_deq_ena, 0);
        tick();
        chk("b2b_count", count, 3);

        // Downstream backpressure in SEND_A, then in SEND_B
        src_first     = 10'h155;
        src_first_rdy = 1'b1;
        tick();
        dst_enq_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            src_first = 10'h3FF;
            #1;
            chk("bp_a_hold", dst_enq_v, 7'h15);
            chk("bp_a_nodeq", src_deq_ena, 0);
            tick();
        end
        dst_enq_rdy   = 1'b1;
        src_first_rdy = 1'b0;
        exp_q.push_back(7'h15);
        exp_q.push_back(7'h45);
        tick();
        dst_enq_rdy   = 1'b0;
        src_first_rdy = 1'b1;
        #1;
        chk("bp_b_nodeq", src_deq_ena, 0);
        chk("bp_b_hold",  dst_enq_v, 7'h45);
        tick();
        chk("bp_b_hold2", dst_enq_v, 7'h45);
        chk("bp_b_count", count, 3);
        src_first_rdy = 1'b0;
        dst_enq_rdy   = 1'b1;
        tick();
        chk("bp_count", count, 4);

        // Upstream not ready to dequeue
        src_first     = 10'h123;
        src_first_rdy = 1'b1;
        src_deq_rdy   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_deq", src_deq_ena, 0);
            chk("stall_enq", dst_enq_ena, 0);
            chk("stall_count", count, 4);
            tick();
        end
        src_first_rdy = 1'b0;
        src_deq_rdy   = 1'b1;

        // Reset while the b item is pending
        src_first     = 10'h2A5;
        src_first_rdy = 1'b1;
        exp_q.push_back(7'h25);
        tick();
        src_first_rdy = 1'b0;
        tick();
        chk("mid_in_b", dst_enq_v, 7'h4A);
        rst = 1'b1;
        #1;
        chk("mid_rst_enq", dst_enq_ena, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_v", dst_enq_v, 0);
        tick();
        chk("mid_rst_enq2", dst_enq_ena, 0);
        rst           = 1'b0;
        src_first     = 10'h0C3;
        src_first_rdy = 1'b1;
        exp_q.push_back(7'h03);
        exp_q.push_back(7'h43);
        tick();
        src_first_rdy = 1'b0;
        chk("post_rst_a", dst_enq_v, 7'h03);
        tick();
        chk("post_rst_b", dst_enq_v, 7'h43);
        tick();
        chk("post_rst_count", count, 1);

        // Counter wrap: jump the counter close to its wrap point instead of 65k elements
        force dut.r_count = 16'hFFFE;
        #1;
        release dut.r_count;
        #1;
        chk("wrap_preload", count, 16'hFFFE);
        src_first     = 10'h3FF;
        src_first_rdy = 1'b1;
        exp_q.push_back(7'h3F);
        exp_q.push_back(7'h4F);
        exp_q.push_back(7'h3F);
        exp_q.push_back(7'h4F);
        tick();
        tick();
        tick();
        src_first_rdy = 1'b0;
        chk("wrap_ffff", count, 16'hFFFF);
        tick();
        tick();
        chk("wrap_zero", count, 16'h0000);

        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
